// File: rtl/power_test_pkg.sv
// power_test_pkg
//   Shared definitions for the power stimulus generator: FSM state encoding,
//   pattern mode encoding, LFSR tap mask and LFSR helper functions.
package power_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_t;

    // Feedback taps at bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fibonacci shift-left: feedback enters at bit 0.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Operand pair {op_b, op_a} produced by the step that advances s.
    function automatic logic [13:0] lfsr_operands(input logic [15:0] s);
        logic [15:0] adv;
        adv = lfsr_advance(s);
        return {adv[14:8], adv[6:0]};
    endfunction

endpackage

// File: rtl/power_lfsr16.sv
// power_lfsr16
//   16-bit Fibonacci LFSR with synchronous reload.
//   Ports:
//     clk   - clock
//     rst   - asynchronous active-high reset, loads SEED
//     load  - reload SEED (has priority over step)
//     step  - advance one position
//     state - current LFSR contents
module power_lfsr16
    import power_test_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_advance(state);
        end
    end

endmodule

// File: rtl/power_stim_gen.sv
// power_stim_gen
//   Operand stimulus generator for exercising a downstream adder's power
//   behaviour. A run is started with start, produces one operand pair every
//   rate+1 cycles in the selected pattern, and ends after burst_len steps
//   (or runs continuously when burst_len is 0) or on stop.
//   Ports:
//     clk, rst          - clock, asynchronous active-high reset
//     start, stop, hold - run control
//     mode, rate        - pattern select, inter-step gap
//     burst_len         - steps per run, 0 = continuous
//     op_a, op_b        - operand outputs (change only on step cycles)
//     op_valid          - one-cycle pulse with each new operand pair
//     busy, done        - run in progress, finite burst finished
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start
//   ST_RUN  | stepping patterns on the rate schedule
//   ST_DONE | one cycle after the final step of a finite burst
module power_stim_gen
    import power_test_pkg::*;
#(
    parameter int          OP_W      = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            hold,
    input  logic [1:0]      mode,
    input  logic [3:0]      rate,
    input  logic [7:0]      burst_len,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            op_valid,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] WALK_LAST = 3'(OP_W - 1);

    state_t          state_q, state_d;
    mode_t           mode_q;
    logic [3:0]      rate_q;
    logic [7:0]      burst_q;
    logic [3:0]      rate_cnt_q;
    logic [7:0]      step_cnt_q;
    logic [2:0]      walk_idx_q;
    logic            toggle_q;
    logic [OP_W-1:0] op_a_q, op_b_q;
    logic            op_valid_q, done_q;
    logic            start_ev, step_ev;
    logic [OP_W-1:0] pat_a, pat_b;
    logic [15:0]     lfsr_state;

    assign start_ev = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop outranks both hold and a coinciding step.
    always_comb begin
        state_d = state_q;
        step_ev = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!hold && rate_cnt_q == rate_q) begin
                    step_ev = 1'b1;
                    if (burst_q != 8'd0 && step_cnt_q + 8'd1 == burst_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    power_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_ev),
        .step  (step_ev && mode_q == MODE_LFSR),
        .state (lfsr_state)
    );

    // Operands for the step about to happen; only sampled on step_ev.
    always_comb begin
        pat_a = '0;
        pat_b = '0;
        case (mode_q)
            MODE_LFSR: begin
                {pat_b, pat_a} = lfsr_operands(lfsr_state);
            end
            MODE_WALK: begin
                pat_a = OP_W'(1) << walk_idx_q;
                pat_b = ~pat_a;
            end
            MODE_TOGGLE: begin
                pat_a = toggle_q ? '0 : '1;
                pat_b = ~pat_a;
            end
            default: begin
                pat_a = '0;
                pat_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_STATIC;
            rate_q     <= '0;
            burst_q    <= '0;
            rate_cnt_q <= '0;
            step_cnt_q <= '0;
            walk_idx_q <= '0;
            toggle_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            op_valid_q <= step_ev;
            done_q     <= (state_q == ST_DONE);
            if (start_ev) begin
                mode_q     <= mode_t'(mode);
                rate_q     <= rate;
                burst_q    <= burst_len;
                rate_cnt_q <= '0;
                step_cnt_q <= '0;
                walk_idx_q <= '0;
                toggle_q   <= 1'b0;
            end else if (state_q == ST_RUN && !stop && !hold) begin
                if (step_ev) begin
                    rate_cnt_q <= '0;
                    step_cnt_q <= step_cnt_q + 8'd1;
                    op_a_q     <= pat_a;
                    op_b_q     <= pat_b;
                    walk_idx_q <= (walk_idx_q == WALK_LAST) ? 3'd0 : walk_idx_q + 3'd1;
                    toggle_q   <= ~toggle_q;
                end else begin
                    rate_cnt_q <= rate_cnt_q + 4'd1;
                end
            end
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_power_stim_gen.sv
// tb_power_stim_gen
//   Directed bench for power_stim_gen. Expected operand pairs (with the
//   cycle they must appear in) and expected done cycles are queued when a
//   run is started and checked by a negedge monitor.
module tb_power_stim_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] rate = 4'd0;
    logic [7:0] burst_len = 8'd0;
    logic [6:0] op_a, op_b;
    logic       op_valid, busy, done;

    power_stim_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .rate      (rate),
        .burst_len (burst_len),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        int         c;
    } step_t;

    step_t      exp_q[$];
    int         done_q[$];
    int         total = 0;
    int         bad = 0;
    logic [6:0] last_a = 7'h00, last_b = 7'h00;
    logic [15:0] m_lfsr;
    int         c0;

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    always @(negedge clk) begin
        step_t e;
        int    d;
        if (rst) begin
            last_a = 7'h00;
            last_b = 7'h00;
        end else begin
            if (op_valid) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_valid cyc=%0d observed=valid required=none", cyc);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert ({op_a, op_b, cyc} === {e.a, e.b, e.c}) else begin
                        bad++;
                        $error("FAIL step a/b/cyc observed=%h/%h/%0d required=%h/%h/%0d",
                               op_a, op_b, cyc, e.a, e.b, e.c);
                    end
                end
            end else begin
                total++;
                assert (op_a === last_a && op_b === last_b) else begin
                    bad++;
                    $error("FAIL stable cyc=%0d observed=%h/%h required=%h/%h",
                           cyc, op_a, op_b, last_a, last_b);
                end
            end
            last_a = op_a;
            last_b = op_b;
            if (done) begin
                total++;
                assert (done_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_done cyc=%0d observed=done required=none", cyc);
                end
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    total++;
                    assert (cyc === d) else begin
                        bad++;
                        $error("FAIL done_cyc observed=%0d required=%0d", cyc, d);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, obs, req);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [3:0] r, input logic [7:0] n);
        @(negedge clk);
        mode = m; rate = r; burst_len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'd0; rate = 4'd0; burst_len = 8'd0;
        c0 = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_q.size() > 0 || done_q.size() > 0); i++)
            @(negedge clk);
        total++;
        assert (exp_q.size() == 0 && done_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout observed=%0d/%0d pending required=0/0", tag,
                   exp_q.size(), done_q.size());
        end
    endtask

    task automatic push_lfsr_run(input int r, input int n);
        m_lfsr = 16'hACE1;
        for (int j = 1; j <= n; j++) begin
            m_lfsr = model_lfsr(m_lfsr);
            exp_q.push_back('{a: m_lfsr[6:0], b: m_lfsr[14:8], c: c0 + j * (r + 1)});
        end
        done_q.push_back(c0 + n * (r + 1) + 1);
    endtask

    initial begin
        logic [6:0] wa;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_op_a", 32'(op_a), 32'h0);
        chk("rst_op_b", 32'(op_b), 32'h0);
        chk("rst_flags", 32'({op_valid, busy, done}), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // LFSR burst of 2, rate 0
        do_start(2'd1, 4'd0, 8'd2);
        push_lfsr_run(0, 2);
        chk("t1_busy", 32'(busy), 32'h1);
        drain("t1", 20);
        chk("t1_busy_end", 32'(busy), 32'h0);

        // walking one, rate 3, burst 8 (wraps after bit 6)
        do_start(2'd2, 4'd3, 8'd8);
        for (int j = 1; j <= 8; j++) begin
            wa = 7'h01 << ((j - 1) % 7);
            exp_q.push_back('{a: wa, b: ~wa, c: c0 + 4 * j});
        end
        done_q.push_back(c0 + 33);
        drain("t2", 60);
        chk("t2_busy_end", 32'(busy), 32'h0);

        // full toggle continuous; stop lands on what would be step 6
        do_start(2'd3, 4'd1, 8'd0);
        for (int j = 1; j <= 5; j++) begin
            wa = (j % 2 == 1) ? 7'h7F : 7'h00;
            exp_q.push_back('{a: wa, b: ~wa, c: c0 + 2 * j});
        end
        wait_cyc(c0 + 11);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        drain("t3", 5);
        chk("t3_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        chk("t3_op_a_held", 32'(op_a), 32'h7F);
        chk("t3_op_b_held", 32'(op_b), 32'h00);

        // hold for 10 cycles between steps 1 and 2
        do_start(2'd2, 4'd3, 8'd0);
        exp_q.push_back('{a: 7'h01, b: 7'h7E, c: c0 + 4});
        exp_q.push_back('{a: 7'h02, b: 7'h7D, c: c0 + 18});
        exp_q.push_back('{a: 7'h04, b: 7'h7B, c: c0 + 22});
        exp_q.push_back('{a: 7'h08, b: 7'h77, c: c0 + 26});
        wait_cyc(c0 + 6);
        hold = 1'b1;
        wait_cyc(c0 + 16);
        chk("t4_hold_op_a", 32'(op_a), 32'h01);
        hold = 1'b0;
        wait_cyc(c0 + 26);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        drain("t4", 5);
        chk("t4_busy", 32'(busy), 32'h0);

        // async reset mid-run, then replay the LFSR burst
        do_start(2'd1, 4'd5, 8'd3);
        exp_q.push_back('{a: 7'h43, b: 7'h59, c: c0 + 6});
        wait_cyc(c0 + 8);
        chk("t5_pre_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        done_q.delete();
        chk("t5_rst_ops", 32'({op_a, op_b}), 32'h0);
        chk("t5_rst_flags", 32'({op_valid, busy, done}), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        do_start(2'd1, 4'd0, 8'd2);
        push_lfsr_run(0, 2);
        drain("t5", 20);
        chk("t5_busy_end", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
